// File: rtl/fp64_add_arbiter.sv
// fp64_add_arbiter
// Round-robin arbiter and sequencer that shares one external combinational
// fp64 adder among NUM_REQ requesters. One operand pair is accepted per
// grant, registered onto the adder, the sum is captured one cycle later and
// returned on a single response port tagged with the requester index.
//
// State table:
//   IDLE | no operation in flight, may grant
//   EXEC | operands on add_a_o/add_b_o, add_s_i settling
//   RESP | rsp_valid_o high, waiting for rsp_ready_i (may grant on accept)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i          per-requester operand valid
//   req_a_i, req_b_i     packed operands, requester i at [64i+63:64i]
//   req_ready_o          one-hot grant
//   add_a_o, add_b_o     registered operands to the external adder
//   add_s_i              combinational sum from the external adder
//   rsp_valid_o, rsp_data_o, rsp_id_o, rsp_ready_i   response handshake
//   busy_o               high in EXEC or RESP
//   op_count_o           number of completed response handshakes
module fp64_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [64*NUM_REQ-1:0]  req_a_i,
    input  logic [64*NUM_REQ-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [63:0]            add_a_o,
    output logic [63:0]            add_b_o,
    input  logic [63:0]            add_s_i,
    output logic                   rsp_valid_o,
    output logic [63:0]            rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       op_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   tag_q;
    logic [63:0]       add_a_q, add_b_q;
    logic              rsp_valid_q;
    logic [63:0]       rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [CNT_W-1:0]  op_count_q;

    logic              can_grant;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic              grant;

    // Search from rr_ptr+1 upward; walking the offsets from farthest to
    // nearest lets the closest valid requester win by overwriting.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign can_grant = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign grant     = can_grant && gnt_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = grant ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o = NUM_REQ'(1) << gnt_idx;
        end
        busy_o = (state_q != IDLE);
    end

    // Pointer resets to the last requester so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            tag_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            if (grant) begin
                add_a_q  <= req_a_i[64*gnt_idx +: 64];
                add_b_q  <= req_b_i[64*gnt_idx +: 64];
                tag_q    <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= add_s_i;
                rsp_id_q    <= tag_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                op_count_q  <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign op_count_o  = op_count_q;

endmodule
